// File: rtl/stream_mux_n_pkg.sv
// Shared helpers for N-channel stream blocks: select-width derivation and
// packed-bus channel slicing.
package stream_mux_n_pkg;

    localparam int unsigned DefaultN = 4;
    localparam int unsigned DefaultW = 8;

    // Never narrower than one bit, so a 2-channel block still has a select line.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // Low bit of channel ch in a packed bus of w-bit channels.
    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Producer/consumer-side bundle of stream_mux_n: N input streams, one output stream,
// channel select and status.
interface stream_mux_n_if
    import stream_mux_n_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned W = DefaultW
);

    localparam int unsigned SELW = sel_width(N);

    logic [SELW-1:0] sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic [SELW-1:0] out_ch;
    logic            locked;
    logic            sel_err;

    // Environment side: producers, consumer and select controller.
    modport master (
        output sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch, locked, sel_err
    );

    // Mux side.
    modport slave (
        input  sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch, locked, sel_err
    );

endinterface

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register stage; loads while draining so a held-high
// out_ready_i sustains one beat per cycle.
module stream_reg_slice #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic             can_load;

    always_comb begin
        can_load = !valid_q || out_ready_i;
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_valid_i && can_load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready_o  = can_load;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/stream_mux_n.sv
// N-input stream multiplexer with registered output and optional packet locking,
// so a packet's beats all come from one channel once its first beat is taken.
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter int unsigned N        = DefaultN,
    parameter int unsigned W        = DefaultW,
    parameter bit          LOCK_PKT = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    stream_mux_n_if.slave bus
);

    localparam int unsigned SELW = sel_width(N);
    localparam int unsigned PW   = W + 1 + SELW;

    logic [SELW-1:0] active_sel_q, active_sel_d;
    logic            locked_q, locked_d;
    logic            sel_err_q, sel_err_d;

    logic [SELW-1:0] grant;
    logic            sel_in_range;
    logic [W-1:0]    grant_data;
    logic            grant_valid;
    logic            grant_last;
    logic            slice_ready;
    logic            accept;
    logic [PW-1:0]   slice_out;

    always_comb begin
        sel_in_range = 32'(bus.sel) < N;
        grant        = active_sel_q;
        if (!locked_q && sel_in_range) begin
            grant = bus.sel;
        end
    end

    // Equality-gated gather keeps non-granted channel data (possibly X) off the outputs.
    always_comb begin
        grant_data   = '0;
        grant_valid  = 1'b0;
        grant_last   = 1'b0;
        bus.in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data      = bus.in_data[slice_lo(i, W) +: W];
                grant_valid     = bus.in_valid[i];
                grant_last      = bus.in_last[i];
                bus.in_ready[i] = slice_ready;
            end
        end
    end

    always_comb begin
        accept       = grant_valid && slice_ready;
        active_sel_d = active_sel_q;
        locked_d     = locked_q;
        if (accept) begin
            active_sel_d = grant;
            locked_d     = LOCK_PKT && !grant_last;
        end
        sel_err_d = !locked_q && !sel_in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_sel_q <= '0;
            locked_q     <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            active_sel_q <= active_sel_d;
            locked_q     <= locked_d;
            sel_err_q    <= sel_err_d;
        end
    end

    stream_reg_slice #(
        .Width (PW)
    ) u_out_slice (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (grant_valid),
        .in_ready_o  (slice_ready),
        .in_data_i   ({grant_last, grant, grant_data}),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (slice_out)
    );

    assign {bus.out_last, bus.out_ch, bus.out_data} = slice_out;
    assign bus.locked  = locked_q;
    assign bus.sel_err = sel_err_q;

    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.in_ready));

    a_hold_under_backpressure : assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(slice_out)));

    a_no_lock_when_disabled : assert property (@(posedge clk) disable iff (!rst_n)
        !LOCK_PKT |-> !locked_q);

    a_out_ch_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid |-> (32'(bus.out_ch) < N));

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench: instance A (N=4, locking) and instance B (N=3, no locking)
// against a cycle-level behavioural model, directed tables and random traffic.
module tb_stream_mux_n;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    stream_mux_n_if #(.N(4), .W(8)) ifa ();
    stream_mux_n_if #(.N(3), .W(8)) ifb ();

    stream_mux_n #(.N(4), .W(8), .LOCK_PKT(1'b1)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    stream_mux_n #(.N(3), .W(8), .LOCK_PKT(1'b0)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus per instance (index 0 = A, 1 = B).
    int          in_sel [2];
    logic [3:0]  in_val [2];
    logic [3:0]  in_lst [2];
    logic [31:0] in_dat [2];
    logic        in_ordy[2];

    // Reference model state.
    logic       m_ov  [2];
    logic [7:0] m_od  [2];
    logic       m_ol  [2];
    int         m_och [2];
    logic       m_lock[2];
    logic       m_err [2];
    int         m_act [2];

    typedef struct {
        int          sel;
        logic [3:0]  val;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        int          e_och;
        logic        e_lock;
    } vec_t;

    vec_t tbl[12];

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic bit lock_en(input int k);
        return k == 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int mgrant(input int k);
        if (m_lock[k]) return m_act[k];
        if (in_sel[k] < nch(k)) return in_sel[k];
        return m_act[k];
    endfunction

    task automatic drive();
        ifa.sel       = 2'(in_sel[0]);
        ifa.in_valid  = in_val[0];
        ifa.in_last   = in_lst[0];
        ifa.in_data   = in_dat[0];
        ifa.out_ready = in_ordy[0];
        ifb.sel       = 2'(in_sel[1]);
        ifb.in_valid  = in_val[1][2:0];
        ifb.in_last   = in_lst[1][2:0];
        ifb.in_data   = in_dat[1][23:0];
        ifb.out_ready = in_ordy[1];
    endtask

    task automatic set_idle(input int k);
        in_sel[k]  = 0;
        in_val[k]  = '0;
        in_lst[k]  = '0;
        in_dat[k]  = '0;
        in_ordy[k] = 1'b1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ov[k]   = 1'b0;
            m_od[k]   = '0;
            m_ol[k]   = 1'b0;
            m_och[k]  = 0;
            m_lock[k] = 1'b0;
            m_err[k]  = 1'b0;
            m_act[k]  = 0;
        end
    endtask

    // One clock edge of the spec's rules, applied to the pre-edge state.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int   g;
            logic room, acc, err_n;
            g     = mgrant(k);
            room  = !m_ov[k] || in_ordy[k];
            acc   = in_val[k][g] && room;
            err_n = !m_lock[k] && (in_sel[k] >= nch(k));
            if (acc) begin
                m_ov[k]  = 1'b1;
                m_od[k]  = in_dat[k][g*8 +: 8];
                m_ol[k]  = in_lst[k][g];
                m_och[k] = g;
                m_act[k] = g;
                m_lock[k] = lock_en(k) && !in_lst[k][g];
            end else if (in_ordy[k]) begin
                m_ov[k] = 1'b0;
            end
            m_err[k] = err_n;
        end
    endtask

    task automatic check_ready();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] e;
            logic [3:0] got;
            int g;
            g = mgrant(k);
            e = '0;
            for (int i = 0; i < nch(k); i++) e[i] = (i == g) && (!m_ov[k] || in_ordy[k]);
            got = (k == 0) ? ifa.in_ready : {1'b0, ifb.in_ready};
            chk($sformatf("model.in_ready[%0d]", k), 32'(got), 32'(e));
        end
    endtask

    task automatic check_outputs();
        chk("model.out_valid[0]", 32'(ifa.out_valid), 32'(m_ov[0]));
        chk("model.out_data[0]",  32'(ifa.out_data),  32'(m_od[0]));
        chk("model.out_last[0]",  32'(ifa.out_last),  32'(m_ol[0]));
        chk("model.out_ch[0]",    32'(ifa.out_ch),    32'(m_och[0]));
        chk("model.locked[0]",    32'(ifa.locked),    32'(m_lock[0]));
        chk("model.sel_err[0]",   32'(ifa.sel_err),   32'(m_err[0]));
        chk("model.out_valid[1]", 32'(ifb.out_valid), 32'(m_ov[1]));
        chk("model.out_data[1]",  32'(ifb.out_data),  32'(m_od[1]));
        chk("model.out_last[1]",  32'(ifb.out_last),  32'(m_ol[1]));
        chk("model.out_ch[1]",    32'(ifb.out_ch),    32'(m_och[1]));
        chk("model.locked[1]",    32'(ifb.locked),    32'(m_lock[1]));
        chk("model.sel_err[1]",   32'(ifb.sel_err),   32'(m_err[1]));
    endtask

    // Entered and left at posedge+1.
    task automatic step();
        drive();
        #1;
        check_ready();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Pass-through, 5-cycle backpressure, locked 3-beat packet on ch1 with sel -> 3.
        tbl[0]  = '{2, 4'b0100, 4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b1, 8'hA5, 1'b1, 2, 1'b0};
        tbl[1]  = '{2, 4'b0100, 4'b0100, 32'h003C_0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 1'b1, 2, 1'b0};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = tbl[1];
        tbl[5]  = tbl[1];
        tbl[6]  = '{2, 4'b0100, 4'b0100, 32'h003C_0000, 1'b1, 4'b0100, 1'b1, 8'h3C, 1'b1, 2, 1'b0};
        tbl[7]  = '{1, 4'b0010, 4'b0000, 32'hDEAD_11EF, 1'b1, 4'b0010, 1'b1, 8'h11, 1'b0, 1, 1'b1};
        tbl[8]  = '{3, 4'b1010, 4'b0000, 32'h9900_2200, 1'b1, 4'b0010, 1'b1, 8'h22, 1'b0, 1, 1'b1};
        tbl[9]  = '{3, 4'b1010, 4'b0010, 32'h9900_3300, 1'b1, 4'b0010, 1'b1, 8'h33, 1'b1, 1, 1'b0};
        tbl[10] = '{3, 4'b1000, 4'b1000, 32'h4400_0000, 1'b1, 4'b1000, 1'b1, 8'h44, 1'b1, 3, 1'b0};
        tbl[11] = '{0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0001, 1'b0, 8'h44, 1'b1, 3, 1'b0};

        set_idle(0);
        set_idle(1);
        drive();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset.out_valid", 32'(ifa.out_valid), 32'd0);
        chk("reset.out_data",  32'(ifa.out_data),  32'd0);
        chk("reset.out_last",  32'(ifa.out_last),  32'd0);
        chk("reset.out_ch",    32'(ifa.out_ch),    32'd0);
        chk("reset.locked",    32'(ifa.locked),    32'd0);
        chk("reset.sel_err",   32'(ifa.sel_err),   32'd0);
        @(posedge clk);
        model_update();
        #1;

        foreach (tbl[r]) begin
            in_sel[0]  = tbl[r].sel;
            in_val[0]  = tbl[r].val;
            in_lst[0]  = tbl[r].lst;
            in_dat[0]  = tbl[r].dat;
            in_ordy[0] = tbl[r].ordy;
            drive();
            #1;
            check_ready();
            chk($sformatf("tbl%0d.in_ready", r), 32'(ifa.in_ready), 32'(tbl[r].e_rdy));
            @(posedge clk);
            model_update();
            #1;
            check_outputs();
            chk($sformatf("tbl%0d.out_valid", r), 32'(ifa.out_valid), 32'(tbl[r].e_ov));
            chk($sformatf("tbl%0d.out_data", r),  32'(ifa.out_data),  32'(tbl[r].e_od));
            chk($sformatf("tbl%0d.out_last", r),  32'(ifa.out_last),  32'(tbl[r].e_ol));
            chk($sformatf("tbl%0d.out_ch", r),    32'(ifa.out_ch),    32'(tbl[r].e_och));
            chk($sformatf("tbl%0d.locked", r),    32'(ifa.locked),    32'(tbl[r].e_lock));
        end

        // Reset in the middle of a held, locked packet.
        in_sel[0] = 0; in_val[0] = 4'b0001; in_lst[0] = 4'b0000;
        in_dat[0] = 32'h0000_00C7; in_ordy[0] = 1'b0;
        step();
        chk("rstmid.pre_valid",  32'(ifa.out_valid), 32'd1);
        chk("rstmid.pre_locked", 32'(ifa.locked),    32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid.out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rstmid.locked",    32'(ifa.locked),    32'd0);
        chk("rstmid.out_data",  32'(ifa.out_data),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_sel[0] = 3; in_val[0] = 4'b1000; in_lst[0] = 4'b1000;
        in_dat[0] = 32'h5A00_0000; in_ordy[0] = 1'b1;
        drive();
        #1;
        chk("rstmid.follow_sel", 32'(ifa.in_ready), 32'b1000);
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
        chk("rstmid.out_ch",   32'(ifa.out_ch),   32'd3);
        chk("rstmid.out_data", 32'(ifa.out_data), 32'h5A);
        set_idle(0);

        // Out-of-range select on the 3-channel instance.
        in_sel[1] = 1; in_val[1] = 4'b0010; in_lst[1] = 4'b0010; in_dat[1] = 32'h0000_7700;
        step();
        in_sel[1] = 3; in_val[1] = 4'b0110; in_lst[1] = 4'b0110; in_dat[1] = 32'h00EE_8800;
        step();
        chk("oob.sel_err_set", 32'(ifb.sel_err),  32'd1);
        chk("oob.kept_grant",  32'(ifb.out_ch),   32'd1);
        chk("oob.data",        32'(ifb.out_data), 32'h88);
        in_sel[1] = 2; in_val[1] = 4'b0100; in_lst[1] = 4'b0100; in_dat[1] = 32'h00EE_0000;
        step();
        chk("oob.sel_err_clr", 32'(ifb.sel_err),  32'd0);
        chk("oob.ch2_beat",    32'(ifb.out_data), 32'hEE);

        // Unlocked interleave: sel toggles every cycle, both channels mid-packet.
        for (int i = 0; i < 8; i++) begin
            in_sel[1]  = i % 2;
            in_val[1]  = 4'b0011;
            in_lst[1]  = 4'b0000;
            in_dat[1]  = {16'h0000, 8'(8'h20 + i), 8'(8'h10 + i)};
            in_ordy[1] = 1'b1;
            step();
            chk($sformatf("ilv%0d.out_valid", i), 32'(ifb.out_valid), 32'd1);
            chk($sformatf("ilv%0d.out_ch", i),    32'(ifb.out_ch),    32'(i % 2));
            chk($sformatf("ilv%0d.out_data", i),  32'(ifb.out_data),
                (i % 2 == 1) ? 32'(8'h20 + i) : 32'(8'h10 + i));
            chk($sformatf("ilv%0d.locked", i),    32'(ifb.locked),    32'd0);
        end

        // Random traffic on both instances against the model.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                in_sel[k]  = int'($urandom_range(0, 3));
                in_val[k]  = 4'($urandom);
                in_lst[k]  = 4'($urandom);
                in_dat[k]  = $urandom;
                in_ordy[k] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
